data_bram: RTL and testbench
============================

# data_bram

Parametrised synchronous data memory for the pipelined datapath's MEM stage: one read/write CPU port with per-byte write strobes and a registered one-cycle read. A second read-only debug port lets the debug unit dump memory. A hardware clear sequencer zeroes the whole array after reset or on request, with a busy flag so the pipeline can stall.

## Interface

- ADDRESS_BITS, 8, word address width; depth MEM_SIZE = 2**ADDRESS_BITS words
- DATA_BITS, 32, word width; must be a multiple of 8; BYTES = DATA_BITS/8 (localparam)

- clk  in  1  single clock; everything on posedge
- rst  in  1  reset, synchronous, active-high
- i_clear  in  1  request full-array zeroing (sampled in IDLE only)
- i_write_enable  in  1  CPU write request
- i_byte_enable  in  BYTES  per-byte write strobe; bit k covers data[8k+7:8k]
- i_read_enable  in  1  CPU read request
- i_address  in  ADDRESS_BITS  CPU word address
- i_data  in  DATA_BITS  CPU write data
- o_data  out  DATA_BITS  CPU read data, registered
- o_valid  out  1  o_data updated by a read accepted last cycle
- i_dbg_address  in  ADDRESS_BITS  debug read address
- o_dbg_data  out  DATA_BITS  debug read data, registered
- o_busy  out  1  clear sweep in progress; CPU port ignored

## Operation

- States: CLEAR, IDLE. Sweep counter clr_addr, ADDRESS_BITS wide.
- rst=1: state←CLEAR, clr_addr←0, o_data←0, o_valid←0, o_dbg_data←0, o_busy←1. No array write occurs in the reset cycle.
- CLEAR: each cycle writes 0 to mem[clr_addr] and increments clr_addr. In the cycle it writes address MEM_SIZE-1, the next state is IDLE and o_busy←0. A sweep takes exactly MEM_SIZE cycles. clr_addr does not wrap past MEM_SIZE-1.
- CLEAR, CPU port: i_write_enable, i_read_enable and i_clear are ignored. o_valid stays 0 and o_data holds its value.
- CLEAR, debug port: stays live and returns old contents or zeros, depending on sweep progress.
- IDLE + i_clear=1: state←CLEAR, clr_addr←0, o_busy←1 next cycle. A CPU access presented in the same cycle as i_clear is still performed.
- Write (IDLE, i_write_enable=1): byte k of mem[i_address] ← byte k of i_data for each k with i_byte_enable[k]=1. Other bytes are unchanged. i_byte_enable=0 makes the write a no-op.
- Read (IDLE, i_read_enable=1): o_data ← mem[i_address] and o_valid←1 on the next edge. With no read, o_valid←0 and o_data holds.
- Simultaneous read and write to the same address: see Configuration.
- Debug port: o_dbg_data ← mem[i_dbg_address] every cycle, unconditionally, read-first. On a same-address CPU write in the same cycle it returns the pre-write word.
- Addresses are word addresses and are used modulo MEM_SIZE; there is no out-of-range condition.
- rst mid-sweep restarts the sweep from address 0. Contents already cleared stay cleared.

## Timing

- CPU read latency: 1 cycle (address at edge N, data and o_valid at edge N+1). Full throughput of one access per cycle.
- Write takes effect at the edge it is sampled. A read of that address issued in the following cycle returns the new data.
- Debug read latency: 1 cycle, every cycle.
- After rst deasserts: o_busy=1 for MEM_SIZE cycles (256 at default), then 0.
- After i_clear in IDLE: o_busy high from the next cycle for MEM_SIZE cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

- DATA_BRAM_FORWARD_EN defined (write-first CPU port): a same-cycle read and write to the same address returns the merged word. Enabled bytes come from i_data; disabled bytes come from the old word.
- DATA_BRAM_FORWARD_EN undefined (read-first CPU port): a same-cycle read and write to the same address returns the old word.
- The debug port is read-first in both builds.

## Test plan

- Reset, then wait: o_busy=1 for exactly 256 cycles, then 0. Debug dump of all 256 addresses returns 0x00000000.
- Write 0xDEADBEEF to addr 0x10 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read addr 0x10: o_data=0xDEADBEAA with o_valid=1 one cycle after the read request.
- Write 0x11223344 to addr 0x05 with be=0, then read addr 0x05: o_data=0x00000000.
- Addr 0x20 holds 0x12345678. In one cycle, write 0xCAFEF00D with be=4'b1100 and read addr 0x20. The read returns 0xCAFE5678 with DATA_BRAM_FORWARD_EN and 0x12345678 without it. Debug port on 0x20 in the same cycle returns 0x12345678.
- Fill addrs 0..3 with nonzero data, then pulse i_clear: o_busy rises next cycle and lasts 256 cycles. A CPU write during busy is ignored, and addrs 0..3 read back 0 afterwards.
- Assert rst at cycle 100 of a sweep: o_busy stays 1, and the sweep restarts and completes 256 cycles after rst deasserts.

Source files
------------

// File: rtl/data_bram.sv
// Synchronous data memory with byte-strobed CPU port, read-only debug port and clear sequencer.
// Define DATA_BRAM_FORWARD_EN for a write-first CPU port (default: read-first).
module data_bram #(
  parameter int ADDRESS_BITS = 8,
  parameter int DATA_BITS    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_write_enable,
  input  logic [DATA_BITS/8-1:0]  i_byte_enable,
  input  logic                    i_read_enable,
  input  logic [ADDRESS_BITS-1:0] i_address,
  input  logic [DATA_BITS-1:0]    i_data,
  output logic [DATA_BITS-1:0]    o_data,
  output logic                    o_valid,
  input  logic [ADDRESS_BITS-1:0] i_dbg_address,
  output logic [DATA_BITS-1:0]    o_dbg_data,
  output logic                    o_busy
);

  localparam int MEM_SIZE = 2 ** ADDRESS_BITS;
  localparam int BYTES    = DATA_BITS / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state, next_state;
  logic [ADDRESS_BITS-1:0] clr_addr;
  logic                    clr_last;
  logic                    clr_write, cpu_write, cpu_read;
  logic [DATA_BITS-1:0]    rd_word;

  // NOTE: the array has no reset; zeroing is done by the clear sweep so it maps onto block RAM.
  logic [DATA_BITS-1:0]    mem [MEM_SIZE];

  assign clr_last = (clr_addr == '1);

  // State register
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  // Next-state logic
  // NOTE: defaults at the top of every always_comb keep it free of inferred latches.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR: if (clr_last) next_state = IDLE;
      IDLE:  if (i_clear)  next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  // Output decode: array and port enables; nothing touches the array in the reset cycle
  always_comb begin
    clr_write = 1'b0;
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    if (!rst) begin
      case (state)
        CLEAR: clr_write = 1'b1;
        IDLE: begin
          cpu_write = i_write_enable;
          cpu_read  = i_read_enable;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_write) begin
      mem[clr_addr] <= '0;
    end else if (cpu_write) begin
      for (int k = 0; k < BYTES; k++) begin
        if (i_byte_enable[k]) mem[i_address][8*k +: 8] <= i_data[8*k +: 8];
      end
    end
  end

`ifdef DATA_BRAM_FORWARD_EN
  // Write-first: merge the enabled bytes of the in-flight write into the read word
  always_comb begin
    rd_word = mem[i_address];
    if (cpu_write) begin
      for (int k = 0; k < BYTES; k++) begin
        if (i_byte_enable[k]) rd_word[8*k +: 8] = i_data[8*k +: 8];
      end
    end
  end
`else
  assign rd_word = mem[i_address];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr   <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_dbg_data <= '0;
      o_busy     <= 1'b1;
    end else begin
      o_busy <= (next_state == CLEAR);
      if (state == CLEAR) begin
        if (!clr_last) clr_addr <= clr_addr + ADDRESS_BITS'(1);
      end else if (i_clear) begin
        clr_addr <= '0;
      end
      o_valid <= cpu_read;
      if (cpu_read) o_data <= rd_word;
      o_dbg_data <= mem[i_dbg_address];
    end
  end

endmodule

// File: tb/tb_data_bram.sv
// Directed self-checking bench for data_bram at default parameters (256 x 32).
// Build with +define+DATA_BRAM_FORWARD_EN to check the write-first variant.
module tb_data_bram;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_clear;
  logic        i_write_enable;
  logic [3:0]  i_byte_enable;
  logic        i_read_enable;
  logic [7:0]  i_address;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_valid;
  logic [7:0]  i_dbg_address;
  logic [31:0] o_dbg_data;
  logic        o_busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  data_bram dut (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (i_clear),
    .i_write_enable (i_write_enable),
    .i_byte_enable  (i_byte_enable),
    .i_read_enable  (i_read_enable),
    .i_address      (i_address),
    .i_data         (i_data),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_dbg_address  (i_dbg_address),
    .o_dbg_data     (o_dbg_data),
    .o_busy         (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are stable 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_clear = 0; i_write_enable = 0; i_read_enable = 0;
    i_byte_enable = '0; i_address = '0; i_data = '0;
  endtask

  task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_inputs();
    i_write_enable = 1; i_address = a; i_data = d; i_byte_enable = be;
    tick();
    idle_inputs();
  endtask

  task automatic read(input logic [7:0] a, output logic [31:0] d, output logic v);
    idle_inputs();
    i_read_enable = 1; i_address = a;
    tick();
    d = o_data; v = o_valid;
    idle_inputs();
  endtask

  // Ticks until o_busy drops, counting cycles; a bound stands in for a hang
  task automatic count_busy(output int cnt, output logic ignored_ok);
    cnt = 0;
    ignored_ok = 1;
    while (o_busy && cnt < 1000) begin
      idle_inputs();
      if (cnt == 200) begin
        i_write_enable = 1; i_byte_enable = 4'hF; i_address = 8'h40;
        i_data = 32'hFFFF_FFFF; i_read_enable = 1; i_clear = 1;
      end
      tick();
      cnt++;
      if (o_busy && o_valid) ignored_ok = 0;
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] d, acc;
    logic        v, ok;
    int          cnt;

    idle_inputs();
    i_dbg_address = '0;
    rst = 1;
    tick();
    tick();
    check("reset_busy",  32'(o_busy), 32'd1);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_data",  o_data, 32'h0);
    check("reset_dbg",   o_dbg_data, 32'h0);

    rst = 0;
    count_busy(cnt, ok);
    check("reset_sweep_cycles", cnt, 256);

    acc = '0;
    for (int a = 0; a < 256; a++) begin
      i_dbg_address = 8'(a);
      tick();
      acc |= o_dbg_data;
    end
    check("dbg_dump_zero", acc, 32'h0);

    // Byte-strobed partial write
    write(8'h10, 32'hDEAD_BEEF, 4'b1111);
    write(8'h10, 32'h0000_00AA, 4'b0001);
    read(8'h10, d, v);
    check("partial_write_data",  d, 32'hDEAD_BEAA);
    check("partial_write_valid", 32'(v), 32'd1);
    tick();
    check("no_read_valid", 32'(o_valid), 32'd0);
    check("no_read_hold",  o_data, 32'hDEAD_BEAA);

    // Write with no strobes is a no-op
    write(8'h05, 32'h1122_3344, 4'b0000);
    read(8'h05, d, v);
    check("be_zero_noop", d, 32'h0);

    // Same-cycle read and write to one address
    write(8'h20, 32'h1234_5678, 4'b1111);
    idle_inputs();
    i_write_enable = 1; i_byte_enable = 4'b1100; i_data = 32'hCAFE_F00D;
    i_read_enable = 1; i_address = 8'h20; i_dbg_address = 8'h20;
    tick();
    idle_inputs();
`ifdef DATA_BRAM_FORWARD_EN
    check("rw_collision_cpu", o_data, 32'hCAFE_5678);
`else
    check("rw_collision_cpu", o_data, 32'h1234_5678);
`endif
    check("rw_collision_dbg", o_dbg_data, 32'h1234_5678);
    tick();
    check("dbg_after_write", o_dbg_data, 32'hCAFE_5678);
    read(8'h20, d, v);
    check("read_after_merge", d, 32'hCAFE_5678);

    // Clear request with a read in the same cycle
    for (int a = 0; a < 4; a++) write(8'(a), 32'h0101_0101 * (a + 1), 4'hF);
    write(8'h80, 32'h5555_AAAA, 4'hF);
    i_clear = 1; i_read_enable = 1; i_address = 8'h03;
    tick();
    idle_inputs();
    check("clear_busy_rise",    32'(o_busy), 32'd1);
    check("clear_same_cycle_rd", o_data, 32'h0404_0404);
    check("clear_same_cycle_v",  32'(o_valid), 32'd1);
    count_busy(cnt, ok);
    check("clear_sweep_cycles", cnt, 256);
    check("busy_valid_low", 32'(ok), 32'd1);
    acc = '0;
    for (int a = 0; a < 4; a++) begin
      read(8'(a), d, v);
      acc |= d;
    end
    check("cleared_0_3", acc, 32'h0);
    read(8'h40, d, v);
    check("busy_write_ignored", d, 32'h0);
    check("post_clear_valid", 32'(v), 32'd1);

    // Reset 100 cycles into a sweep restarts it from address 0
    write(8'h80, 32'h5555_AAAA, 4'hF);
    i_clear = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 99; i++) tick();
    check("mid_sweep_busy", 32'(o_busy), 32'd1);
    rst = 1;
    tick();
    check("mid_reset_busy", 32'(o_busy), 32'd1);
    rst = 0;
    count_busy(cnt, ok);
    check("restart_sweep_cycles", cnt, 256);
    read(8'h80, d, v);
    check("restart_cleared", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
